// File: rtl/dither_pkg.sv
// dither_pkg: shared types and constants for the dithered rectangle fill.
//   state_t      - fill sequencer states
//   DEF_*        - default parameter values for dither_fill
//   lane_nbyte() - byte lane (address[1:0]) to active-low byte enables
package dither_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, CALC, WRITE} state_t;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_IN_BITS  = 8;
  localparam int DEF_OUT_BITS = 3;
  localparam int DEF_ADDR_W   = 18;

  function automatic logic [3:0] lane_nbyte(input logic [1:0] lane);
    return ~(4'b0001 << lane);
  endfunction

endpackage

// File: rtl/dither_quant.sv
// dither_quant: combinational error-diffusion quantiser.
//   colour - requested colour (IN_BITS)
//   carry  - error carried from the pixel to the left (signed IN_BITS+2)
//   below  - error pushed down from the row above (signed IN_BITS+2)
//   v      - saturated corrected value
//   q      - rounded OUT_BITS drawn colour
//   err    - residual v - (q << (IN_BITS-OUT_BITS)), signed IN_BITS+2
module dither_quant
  import dither_pkg::*;
#(
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS
) (
  input  logic        [IN_BITS-1:0]  colour,
  input  logic signed [IN_BITS+1:0]  carry,
  input  logic signed [IN_BITS+1:0]  below,
  output logic        [IN_BITS-1:0]  v,
  output logic        [OUT_BITS-1:0] q,
  output logic signed [IN_BITS+1:0]  err
);
  localparam int SH = IN_BITS - OUT_BITS;
  // Two spare headroom bits above the sign so no operand mix can wrap.
  localparam int SW = IN_BITS + 4;

  logic signed [SW-1:0]       sum;
  logic        [OUT_BITS-1:0] qt;

  always_comb begin
    sum = $signed({4'b0000, colour})
        + {{2{carry[IN_BITS+1]}}, carry}
        + {{2{below[IN_BITS+1]}}, below};
    if (sum[SW-1])                v = '0;
    else if (|sum[SW-2:IN_BITS])  v = '1;
    else                          v = sum[IN_BITS-1:0];
    qt = v[IN_BITS-1 -: OUT_BITS];
    // Round half up, but never wrap the top code back to zero.
    q   = (v[SH-1] && !(&qt)) ? qt + OUT_BITS'(1) : qt;
    err = $signed({2'b00, v}) - $signed({2'b00, q, {SH{1'b0}}});
  end

endmodule

// File: rtl/dither_fill.sv
// dither_fill: fills an inclusive rectangle with an error-diffused colour,
// one byte write per pixel through a 32-bit req/ack memory port.
//   clk, reset        - clock, synchronous active-high reset
//   req/ack/busy      - command handshake; r0..r3 = x0,y0,x1,y1, r4 = colour
//   de_*              - memory write port (byte enables active low, write only)
// Build option: DITHER_2D_EN adds a per-column error buffer so half of each
// pixel's error is pushed to the row below; otherwise all error goes right.
module dither_fill
  import dither_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  output logic              ack,
  output logic              busy,
  input  logic [15:0]       r0,
  input  logic [15:0]       r1,
  input  logic [15:0]       r2,
  input  logic [15:0]       r3,
  input  logic [15:0]       r4,
  input  logic [15:0]       r5,
  input  logic [15:0]       r6,
  input  logic [15:0]       r7,
  output logic              de_req,
  input  logic              de_ack,
  output logic [ADDR_W-1:0] de_addr,
  output logic [3:0]        de_nbyte,
  output logic              de_rnw,
  output logic [31:0]       de_w_data,
  input  logic [31:0]       de_r_data
);
  localparam int EW = IN_BITS + 2;
  localparam int AW = ADDR_W + 2;
  localparam logic [15:0] SW16 = 16'(SCREEN_W);

  state_t                 state;
  logic [15:0]            xs, xe, ye, x, y;
  logic [IN_BITS-1:0]     colour;
  logic signed [EW-1:0]   carry, carry_n, below, err;
  logic [IN_BITS-1:0]     v;
  logic [OUT_BITS-1:0]    q;
  logic [AW-1:0]          pix_addr;
  logic                   last_x, last_y;

  assign pix_addr = AW'(32'(x) + 32'(y) * 32'(SCREEN_W));
  assign last_x   = (x == xe);
  assign last_y   = (y == ye);
  assign busy     = (state != IDLE);
  assign de_rnw   = 1'b0;

  logic unused;
  assign unused = ^{r4[15:IN_BITS], r5, r6, r7, de_r_data, v};

  dither_quant #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_quant (
    .colour (colour),
    .carry  (carry),
    .below  (below),
    .v      (v),
    .q      (q),
    .err    (err)
  );

`ifdef DITHER_2D_EN
  localparam int XW = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
  logic signed [EW-1:0] ebuf [SCREEN_W];
  logic [XW-1:0]        ex;
  logic                 eb_we;
  logic signed [EW-1:0] eb_wd;

  assign ex      = x[XW-1:0];
  assign below   = ebuf[ex];
  assign carry_n = err >>> 1;

  // CLEAR zeroes the span; CALC replaces the entry just consumed with the
  // share of error destined for the same column one row down.
  always_comb begin
    eb_we = (state == CLEAR) || (state == CALC);
    eb_wd = (state == CLEAR) ? '0 : err - carry_n;
  end

  always_ff @(posedge clk) begin
    if (eb_we) ebuf[ex] <= eb_wd;
  end
`else
  assign below   = '0;
  assign carry_n = err;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ack    <= 1'b0;
      de_req <= 1'b0;
      carry  <= '0;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: if (req) begin
          ack    <= 1'b1;
          xs     <= r0;
          xe     <= r2;
          ye     <= r3;
          x      <= r0;
          y      <= r1;
          colour <= r4[IN_BITS-1:0];
          carry  <= '0;
          if (!(r2 < r0 || r3 < r1 || r2 >= SW16)) state <= CLEAR;
        end
        CLEAR: begin
`ifdef DITHER_2D_EN
          if (last_x) begin
            x     <= xs;
            state <= CALC;
          end else begin
            x <= x + 16'd1;
          end
`else
          state <= CALC;
`endif
        end
        CALC: begin
          de_req    <= 1'b1;
          de_addr   <= pix_addr[AW-1:2];
          de_nbyte  <= lane_nbyte(pix_addr[1:0]);
          de_w_data <= {4{8'(q)}};
          // Error heading right past the span edge is dropped, which also
          // starts the next row with zero carry.
          carry     <= last_x ? '0 : carry_n;
          state     <= WRITE;
        end
        WRITE: if (de_ack) begin
          de_req <= 1'b0;
          if (last_x) begin
            x <= xs;
            if (last_y) begin
              state <= IDLE;
            end else begin
              y     <= y + 16'd1;
              state <= CALC;
            end
          end else begin
            x     <= x + 16'd1;
            state <= CALC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dither_fill.sv
module tb_dither_fill;
  localparam int SW = 640;
`ifdef DITHER_2D_EN
  localparam bit TWO_D = 1'b1;
`else
  localparam bit TWO_D = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, req, ack, busy, de_req, de_ack, de_rnw;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [17:0] de_addr;
  logic [3:0]  de_nbyte;
  logic [31:0] de_w_data, de_r_data;

  always #5 clk = ~clk;

  dither_fill dut (
    .clk(clk), .reset(reset), .req(req), .ack(ack), .busy(busy),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .de_req(de_req), .de_ack(de_ack), .de_addr(de_addr), .de_nbyte(de_nbyte),
    .de_rnw(de_rnw), .de_w_data(de_w_data), .de_r_data(de_r_data)
  );

  int n_chk = 0;
  int n_fail = 0;
  int exp_a[$], exp_nb[$], exp_d[$];
  int act_a[$], act_nb[$], act_d[$];

  typedef struct {
    int xs, ys, xe, ye, col, stall;
    int exp_n, exp_a0, exp_nb0, exp_q0, exp_qall;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected write list straight from the dithering rules.
  task automatic model(input int xs, ys, xe, ye, col);
    int below[SW];
    int carry, v, q, e, a;
    exp_a.delete(); exp_nb.delete(); exp_d.delete();
    if (xe < xs || ye < ys || xe >= SW) return;
    foreach (below[i]) below[i] = 0;
    for (int y = ys; y <= ye; y++) begin
      carry = 0;
      for (int x = xs; x <= xe; x++) begin
        v = col + carry + (TWO_D ? below[x] : 0);
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        q = v / 32;
        if ((v % 32) >= 16 && q < 7) q++;
        e = v - q * 32;
        if (TWO_D) begin
          carry = e >>> 1;
          below[x] = e - carry;
        end else begin
          carry = e;
        end
        a = x + y * SW;
        exp_a.push_back(a / 4);
        exp_nb.push_back(15 & ~(1 << (a % 4)));
        exp_d.push_back(q * 32'h01010101);
      end
    end
  endtask

  // stall < 0: random 0..2 wait cycles per write; hold keeps req high throughout.
  task automatic run_cmd(input int xs, ys, xe, ye, col, stall, input bit hold);
    int cyc, last_acc, extra, wait_cnt, tgt, budget;
    bit in_req, acked_prev, done;
    logic [31:0] ca, cn, cd;
    model(xs, ys, xe, ye, col);
    act_a.delete(); act_nb.delete(); act_d.delete();
    budget = 100 + (xe >= xs ? xe - xs + 1 : 0) + 2 * exp_a.size() * ((stall < 0 ? 3 : stall) + 3);
    @(negedge clk);
    r0 = 16'(xs); r1 = 16'(ys); r2 = 16'(xe); r3 = 16'(ye); r4 = 16'(col);
    req = 1'b1; de_ack = 1'b0;
    @(negedge clk);
    if (!hold) req = 1'b0;
    chk("ack", ack, 1);
    chk("busy", busy, exp_a.size() > 0);
    cyc = 0; last_acc = -1; extra = 0; wait_cnt = 0; tgt = 0;
    in_req = 0; acked_prev = 0; done = 0;
    ca = 0; cn = 0; cd = 0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      de_ack = 1'b0;
      if (ack) extra++;
      if (acked_prev) begin
        chk("de_req_drop", de_req, 0);
        acked_prev = 0;
      end else if (de_req) begin
        if (!in_req) begin
          in_req = 1; wait_cnt = 0;
          ca = 32'(de_addr); cn = 32'(de_nbyte); cd = de_w_data;
          tgt = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
        end else begin
          chk("hold_addr", 32'(de_addr), ca);
          chk("hold_nbyte", 32'(de_nbyte), cn);
          chk("hold_data", de_w_data, cd);
        end
        if (wait_cnt >= tgt) begin
          de_ack = 1'b1;
          act_a.push_back(ca); act_nb.push_back(cn); act_d.push_back(cd);
          in_req = 0; acked_prev = 1;
          if (stall == 0 && last_acc >= 0) chk("throughput_gap", cyc - last_acc, 2);
          last_acc = cyc;
        end else begin
          wait_cnt++;
        end
      end
      if (!busy && !de_req) begin
        done = 1; req = 1'b0;
      end else if (cyc >= budget) begin
        chk("timeout", 0, 1);
        done = 1; req = 1'b0; de_ack = 1'b0;
      end
    end
    chk("extra_ack", extra, 0);
    chk("write_count", act_a.size(), exp_a.size());
    for (int i = 0; i < act_a.size() && i < exp_a.size(); i++) begin
      chk("model_addr", act_a[i], exp_a[i]);
      chk("model_nbyte", act_nb[i], exp_nb[i]);
      chk("model_data", act_d[i], exp_d[i]);
    end
  endtask

  initial begin
    int hq[4], ha[4], hn[4];
    int n, cyc, bad, xs, xe, ys, ye;

    vt[0] = '{0, 0, 0, 0, 'hE0, 0, 1, 0, 'hE, 7, 7};
    vt[1] = '{0, 0, 3, 0, 'hFF, 0, 4, 0, 'hE, 7, 7};
    vt[2] = '{0, 0, 640, 0, 'h55, 0, 0, 0, 0, 0, -1};
    vt[3] = '{5, 0, 4, 0, 'h55, 0, 0, 0, 0, 0, -1};
    vt[4] = '{0, 3, 0, 2, 'h55, 0, 0, 0, 0, 0, -1};
    vt[5] = '{636, 10, 639, 10, 'h80, -1, 4, 1759, 'hE, 4, 4};
    vt[6] = '{0, 1, 639, 1, 'h40, 0, 640, 160, 'hE, 2, 2};

    reset = 1'b1; req = 1'b0; de_ack = 1'b0;
    r0 = 0; r1 = 0; r2 = 0; r3 = 0; r4 = 0; r5 = 0; r6 = 0; r7 = 0;
    de_r_data = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_de_req", de_req, 0);
    chk("de_rnw", de_rnw, 0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_cmd(vt[i].xs, vt[i].ys, vt[i].xe, vt[i].ye, vt[i].col, vt[i].stall, 1'b0);
      chk("tbl_count", act_a.size(), vt[i].exp_n);
      if (vt[i].exp_n > 0 && act_a.size() > 0) begin
        chk("tbl_addr0", act_a[0], vt[i].exp_a0);
        chk("tbl_nbyte0", act_nb[0], vt[i].exp_nb0);
        chk("tbl_data0", act_d[0], vt[i].exp_q0 * 32'h01010101);
      end
      if (vt[i].exp_qall >= 0)
        foreach (act_d[j]) chk("tbl_qall", act_d[j], vt[i].exp_qall * 32'h01010101);
    end

    // Hand-worked dither pattern for a small span.
`ifdef DITHER_2D_EN
    hq = '{1, 0, 0, 1}; ha = '{0, 0, 160, 160}; hn = '{'hE, 'hD, 'hE, 'hD};
    run_cmd(0, 0, 1, 1, 'h10, 0, 1'b0);
`else
    hq = '{1, 0, 1, 0}; ha = '{0, 0, 0, 0}; hn = '{'hE, 'hD, 'hB, 'h7};
    run_cmd(0, 0, 3, 0, 'h10, 0, 1'b0);
`endif
    chk("hand_count", act_a.size(), 4);
    for (int i = 0; i < 4 && i < act_a.size(); i++) begin
      chk("hand_q", act_d[i], hq[i] * 32'h01010101);
      chk("hand_addr", act_a[i], ha[i]);
      chk("hand_nbyte", act_nb[i], hn[i]);
    end

    // Long de_ack stall with req held high the whole time.
    run_cmd(10, 2, 12, 2, 'h9C, 5, 1'b1);

    for (int k = 0; k < 12; k++) begin
      xs = $urandom_range(0, 639);
      xe = xs + $urandom_range(0, 5);
      ys = $urandom_range(0, 200);
      ye = ys + $urandom_range(0, 2);
      if ($urandom_range(0, 7) == 0) begin n = xs; xs = xe; xe = n; end
      run_cmd(xs, ys, xe, ye, $urandom_range(0, 255), -1, 1'b0);
    end

    // Reset while a row is in flight.
    @(negedge clk);
    r0 = 0; r1 = 5; r2 = 7; r3 = 5; r4 = 16'h33; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    n = 0; cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      de_ack = 1'b0;
      if (de_req) begin
        if (n == 3) break;
        n++;
        de_ack = 1'b1;
      end
    end
    chk("midrow_reached", de_req, 1);
    de_ack = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("midrst_de_req", de_req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ack", ack, 0);
    reset = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (de_req || busy || ack) bad++;
    end
    chk("post_rst_quiet", bad, 0);
    run_cmd(2, 7, 5, 8, 'hA7, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dither_fill.md
DITHER_FILL -- requirements
Module: dither_fill

Interface
REQ-001 Parameters SHALL be: SCREEN_W, default 640, pixels per row; IN_BITS, default 8, input colour width; OUT_BITS, default 3, drawn colour width (< IN_BITS, ≤ 8); ADDR_W, default 18, word address width.
REQ-002 Ports SHALL be: clk  in  1  sole clock; reset  in  1  synchronous active-high reset.
REQ-003 req  in  1  command request; ack  out  1  one-cycle command accept pulse; busy  out  1  high while not IDLE.
REQ-004 r0..r3  in  16 each  x_start, y_start, x_end, y_end (inclusive); r4  in  16  colour in [IN_BITS-1:0]; r5..r7  in  16  unused.
REQ-005 de_req  out  1; de_ack  in  1; de_addr  out  ADDR_W; de_nbyte  out  4  active-low byte enables; de_rnw  out  1  tied 0; de_w_data  out  32; de_r_data  in  32  unused.

Function
REQ-006 States SHALL be IDLE, CLEAR, CALC, WRITE; transitions IDLE->CLEAR on req, CLEAR->CALC after clearing, CALC->WRITE, WRITE->CALC on de_ack (more pixels), WRITE->IDLE on de_ack after last pixel.
REQ-007 In IDLE with req high, block SHALL latch r0..r4, pulse ack for exactly the next cycle, and ignore req in all other states.
REQ-008 If x_end<x_start, y_end<y_start or x_end>=SCREEN_W, block SHALL pulse ack, perform no writes, and stay IDLE.
REQ-009 CLEAR SHALL zero error-buffer entries x_start..x_end, one per cycle (x_end-x_start+1 cycles).
REQ-010 Raster order SHALL be x ascending within row, rows ascending; horizontal carry error SHALL be zero at the start of each row.
REQ-011 CALC SHALL form v = colour + carry + below[x] (below term only per REQ-019), saturated to [0, 2^IN_BITS-1].
REQ-012 Quantisation: q = v[IN_BITS-1 -: OUT_BITS], incremented by 1 if bit IN_BITS-OUT_BITS-1 set and q not all-ones; err = v - (q << (IN_BITS-OUT_BITS)), signed IN_BITS+2 bits.
REQ-013 Pixel address SHALL be x + y*SCREEN_W; de_addr = address[ADDR_W+1:2]; lane = address[1:0] gives de_nbyte 1110/1101/1011/0111 for lanes 0..3.
REQ-014 de_w_data SHALL be q zero-extended to 8 bits replicated into all four bytes.
REQ-015 In WRITE, de_req SHALL be high with de_addr, de_nbyte, de_w_data stable until de_ack is sampled high; de_req SHALL drop in the cycle after the last de_ack.
REQ-016 Throughput SHALL be one pixel per 2 cycles when de_ack is high on first de_req cycle.
REQ-017 Error pushed right past x_end SHALL be discarded.

Reset
REQ-018 reset SHALL force IDLE, ack=0, de_req=0, carry=0 at the next edge, including mid-command (no ack, no further writes); error buffer contents need not reset.

Configuration
REQ-019 Macro DITHER_2D_EN: defined -> carry = err>>>1 (arithmetic), below[x] = err - (err>>>1) written back, below[x] read in REQ-011; undefined -> carry = err, no error buffer, CLEAR lasts 1 cycle.

Structure
REQ-020 Package dither_pkg SHALL hold state enum, default parameter constants, and lane-to-nbyte function.
REQ-021 Sub-module dither_quant SHALL implement REQ-011/REQ-012 combinationally (v, q, err).

Verification
REQ-022 (0,0)-(0,0), colour 0xE0 -> one write, de_addr 0, de_nbyte 1110, de_w_data 0x07070707.
REQ-023 2D off, (0,0)-(3,0), colour 0x10 -> q sequence 1,0,1,0 at lanes 0..3 of de_addr 0.
REQ-024 2D on, (0,0)-(1,1), colour 0x10 -> row0 q 1,0; row1 q 0,1 at de_addr 160, nbyte 1110 then 1101.
REQ-025 colour 0xFF, 4 pixels -> all q=7 (saturation, no wrap); x_end 640 -> ack, no de_req.
REQ-026 de_ack held low 5 cycles -> de_req, de_addr, de_w_data unchanged throughout; reset asserted mid-row -> de_req low next cycle, busy low, no ack.
